axi4_aw_fifo: RTL and testbench



---
 rtl/axi4_rab_aw_pkg.sv | 60 ++++++
 rtl/axi_fifo_rab.sv | 97 +++++++++
 rtl/axi4_aw_fifo.sv | 101 ++++++++++
 tb/tb_axi4_aw_fifo.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_rab_aw_pkg.sv
// rtl/axi4_rab_aw_pkg.sv - AW beat field layout and pack/unpack helpers
// Word layout from LSB: cache, prot, lock, burst, size, len, addr, region, qos, id, user.
// The fixed-width control fields sit in aw_beat_t; addr/id/user are placed around them by offset.
package axi4_rab_aw_pkg;

  // Control fields below awaddr: cache(4) prot(3) lock(1) burst(2) size(3) len(8)
  localparam int AW_LO_W    = 21;
  // Control fields between awaddr and awid: region(4) qos(4)
  localparam int AW_HI_W    = 8;
  localparam int AW_FIXED_W = AW_LO_W + AW_HI_W;

  // Packed MSB-first, so cache lands at bit 0 and qos at the top.
  typedef struct packed {
    logic [3:0] qos;
    logic [3:0] region;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [2:0] prot;
    logic [3:0] cache;
  } aw_beat_t;

  function automatic int aw_off_addr();
    return AW_LO_W;
  endfunction

  function automatic int aw_off_region(input int addr_w);
    return AW_LO_W + addr_w;
  endfunction

  function automatic int aw_off_id(input int addr_w);
    return AW_FIXED_W + addr_w;
  endfunction

  function automatic int aw_off_user(input int addr_w, input int id_w);
    return AW_FIXED_W + addr_w + id_w;
  endfunction

  function automatic int aw_word_w(input int addr_w, input int id_w, input int user_w);
    return AW_FIXED_W + addr_w + id_w + user_w;
  endfunction

  function automatic logic [AW_LO_W-1:0] aw_pack_lo(input aw_beat_t b);
    return {b.len, b.size, b.burst, b.lock, b.prot, b.cache};
  endfunction

  function automatic logic [AW_HI_W-1:0] aw_pack_hi(input aw_beat_t b);
    return {b.qos, b.region};
  endfunction

  function automatic aw_beat_t aw_unpack(input logic [AW_LO_W-1:0] lo,
                                         input logic [AW_HI_W-1:0] hi);
    aw_beat_t b;
    {b.len, b.size, b.burst, b.lock, b.prot, b.cache} = lo;
    {b.qos, b.region} = hi;
    return b;
  endfunction

endpackage

// File: rtl/axi_fifo_rab.sv
// rtl/axi_fifo_rab.sv - generic W-bit circular FIFO with fall-through, flush and occupancy
// clk/rst         : clock, synchronous active-high reset
// flush           : drop all entries on the next edge; blocks both handshakes this cycle
// in_t*           : write side (tdata/tvalid/tready)
// out_t*          : read side (tdata/tvalid/tready)
// count           : occupancy, almost_full : count >= ALMOST_FULL_TH
module axi_fifo_rab
  import axi4_rab_aw_pkg::*;
#(
  parameter int W              = 8,
  parameter int DEPTH          = 4,
  parameter int FALL_THROUGH   = 0,
  parameter int ALMOST_FULL_TH = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [W-1:0]               in_tdata,
  input  logic                       in_tvalid,
  output logic                       in_tready,
  output logic [W-1:0]               out_tdata,
  output logic                       out_tvalid,
  input  logic                       out_tready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_TH    = CNT_W'(ALMOST_FULL_TH);
  localparam bit               FT       = (FALL_THROUGH != 0);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic empty, bypass, push, pop, wr_en, rd_en;

  // Explicit wrap keeps non-power-of-2 depths correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty      = (count_q == '0);
    bypass     = FT && empty;
    in_tready  = (count_q != FULL_CNT) && !flush;
    out_tvalid = (bypass ? in_tvalid : !empty) && !flush;
    out_tdata  = bypass ? in_tdata : mem_q[rd_ptr_q];
    push       = in_tvalid && in_tready;
    pop        = out_tvalid && out_tready;
    // A bypassed beat that is taken immediately never touches storage.
    wr_en      = push && !(bypass && pop);
    rd_en      = pop && !bypass;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_tdata;
  end

  assign count       = count_q;
  assign almost_full = (count_q >= AF_TH);

endmodule

// File: rtl/axi4_aw_fifo.sv
// rtl/axi4_aw_fifo.sv - parametrised AXI4 AW-channel FIFO in front of the RAB translation stage
// axi4_aclk/axi4_arst : clock, synchronous active-high reset
// flush               : discard all stored beats
// s_axi4_aw*          : slave-side AW channel (beats in)
// m_axi4_aw*          : master-side AW channel (beats out, strict FIFO order)
// count/almost_full   : occupancy status
module axi4_aw_fifo
  import axi4_rab_aw_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 4,
  parameter int DEPTH          = 4,
  parameter int FALL_THROUGH   = 0,
  parameter int ALMOST_FULL_TH = DEPTH - 1
) (
  input  logic                       axi4_aclk,
  input  logic                       axi4_arst,
  input  logic                       flush,

  input  logic [AXI_ID_WIDTH-1:0]    s_axi4_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]  s_axi4_awaddr,
  input  logic [7:0]                 s_axi4_awlen,
  input  logic [2:0]                 s_axi4_awsize,
  input  logic [1:0]                 s_axi4_awburst,
  input  logic                       s_axi4_awlock,
  input  logic [2:0]                 s_axi4_awprot,
  input  logic [3:0]                 s_axi4_awcache,
  input  logic [3:0]                 s_axi4_awregion,
  input  logic [3:0]                 s_axi4_awqos,
  input  logic [AXI_USER_WIDTH-1:0]  s_axi4_awuser,
  input  logic                       s_axi4_awvalid,
  output logic                       s_axi4_awready,

  output logic [AXI_ID_WIDTH-1:0]    m_axi4_awid,
  output logic [AXI_ADDR_WIDTH-1:0]  m_axi4_awaddr,
  output logic [7:0]                 m_axi4_awlen,
  output logic [2:0]                 m_axi4_awsize,
  output logic [1:0]                 m_axi4_awburst,
  output logic                       m_axi4_awlock,
  output logic [2:0]                 m_axi4_awprot,
  output logic [3:0]                 m_axi4_awcache,
  output logic [3:0]                 m_axi4_awregion,
  output logic [3:0]                 m_axi4_awqos,
  output logic [AXI_USER_WIDTH-1:0]  m_axi4_awuser,
  output logic                       m_axi4_awvalid,
  input  logic                       m_axi4_awready,

  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int W        = aw_word_w(AXI_ADDR_WIDTH, AXI_ID_WIDTH, AXI_USER_WIDTH);
  localparam int OFF_ADDR = aw_off_addr();
  localparam int OFF_REG  = aw_off_region(AXI_ADDR_WIDTH);
  localparam int OFF_ID   = aw_off_id(AXI_ADDR_WIDTH);
  localparam int OFF_USER = aw_off_user(AXI_ADDR_WIDTH, AXI_ID_WIDTH);

  aw_beat_t     s_ctl, m_ctl;
  logic [W-1:0] in_word, out_word;

  assign s_ctl = {s_axi4_awqos, s_axi4_awregion, s_axi4_awlen, s_axi4_awsize,
                  s_axi4_awburst, s_axi4_awlock, s_axi4_awprot, s_axi4_awcache};

  assign in_word = {s_axi4_awuser, s_axi4_awid, aw_pack_hi(s_ctl),
                    s_axi4_awaddr, aw_pack_lo(s_ctl)};

  axi_fifo_rab #(
    .W              (W),
    .DEPTH          (DEPTH),
    .FALL_THROUGH   (FALL_THROUGH),
    .ALMOST_FULL_TH (ALMOST_FULL_TH)
  ) u_fifo (
    .clk         (axi4_aclk),
    .rst         (axi4_arst),
    .flush       (flush),
    .in_tdata    (in_word),
    .in_tvalid   (s_axi4_awvalid),
    .in_tready   (s_axi4_awready),
    .out_tdata   (out_word),
    .out_tvalid  (m_axi4_awvalid),
    .out_tready  (m_axi4_awready),
    .count       (count),
    .almost_full (almost_full)
  );

  assign m_ctl = aw_unpack(out_word[OFF_ADDR-1:0], out_word[OFF_ID-1:OFF_REG]);

  assign m_axi4_awaddr   = out_word[OFF_REG-1:OFF_ADDR];
  assign m_axi4_awid     = out_word[OFF_USER-1:OFF_ID];
  assign m_axi4_awuser   = out_word[W-1:OFF_USER];
  assign m_axi4_awlen    = m_ctl.len;
  assign m_axi4_awsize   = m_ctl.size;
  assign m_axi4_awburst  = m_ctl.burst;
  assign m_axi4_awlock   = m_ctl.lock;
  assign m_axi4_awprot   = m_ctl.prot;
  assign m_axi4_awcache  = m_ctl.cache;
  assign m_axi4_awregion = m_ctl.region;
  assign m_axi4_awqos    = m_ctl.qos;

endmodule

// File: tb/tb_axi4_aw_fifo.sv
// tb/tb_axi4_aw_fifo.sv - directed and scoreboard bench for axi4_aw_fifo
// Instance 0: DEPTH=4 FT=0, instance 1: DEPTH=3 FT=0, instance 2: DEPTH=4 FT=1.
module tb_axi4_aw_fifo;

  localparam int NCFG = 3;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        s_valid;
  logic [68:0] s_word;

  logic        m_ready [NCFG];
  logic        m_valid [NCFG];
  logic        s_ready [NCFG];
  logic [68:0] m_word  [NCFG];
  logic [2:0]  cnt     [NCFG];
  logic        af      [NCFG];

  int checks = 0;
  int errors = 0;

  logic [3:0]  s_id, s_region, s_qos, s_user, s_cache;
  logic [31:0] s_addr;
  logic [7:0]  s_len;
  logic [2:0]  s_size, s_prot;
  logic [1:0]  s_burst;
  logic        s_lock;

  assign {s_id, s_addr, s_len, s_size, s_burst, s_lock, s_prot, s_cache,
          s_region, s_qos, s_user} = s_word;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int DEP = (g == 1) ? 3 : 4;
    localparam int FT  = (g == 2) ? 1 : 0;

    logic [$clog2(DEP+1)-1:0] c;
    logic [3:0]  id, region, qos, user, cache;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size, prot;
    logic [1:0]  burst;
    logic        lock;

    axi4_aw_fifo #(.DEPTH(DEP), .FALL_THROUGH(FT)) u_dut (
      .axi4_aclk       (clk),
      .axi4_arst       (rst),
      .flush           (flush),
      .s_axi4_awid     (s_id),
      .s_axi4_awaddr   (s_addr),
      .s_axi4_awlen    (s_len),
      .s_axi4_awsize   (s_size),
      .s_axi4_awburst  (s_burst),
      .s_axi4_awlock   (s_lock),
      .s_axi4_awprot   (s_prot),
      .s_axi4_awcache  (s_cache),
      .s_axi4_awregion (s_region),
      .s_axi4_awqos    (s_qos),
      .s_axi4_awuser   (s_user),
      .s_axi4_awvalid  (s_valid),
      .s_axi4_awready  (s_ready[g]),
      .m_axi4_awid     (id),
      .m_axi4_awaddr   (addr),
      .m_axi4_awlen    (len),
      .m_axi4_awsize   (size),
      .m_axi4_awburst  (burst),
      .m_axi4_awlock   (lock),
      .m_axi4_awprot   (prot),
      .m_axi4_awcache  (cache),
      .m_axi4_awregion (region),
      .m_axi4_awqos    (qos),
      .m_axi4_awuser   (user),
      .m_axi4_awvalid  (m_valid[g]),
      .m_axi4_awready  (m_ready[g]),
      .count           (c),
      .almost_full     (af[g])
    );

    assign m_word[g] = {id, addr, len, size, burst, lock, prot, cache, region, qos, user};
    assign cnt[g]    = 3'(c);
  end

  // Beat with every field distinct so a field swap in pack/unpack shows up.
  function automatic logic [68:0] mk(input logic [3:0] id, input logic [31:0] addr,
                                     input logic [7:0] len);
    return {id, addr, len, 3'd2, 2'b01, id[0], 3'd5, 4'hA, ~id, 4'hC, id ^ 4'h9};
  endfunction

  task automatic apply_reset();
    rst     = 1'b1;
    flush   = 1'b0;
    s_valid = 1'b0;
    s_word  = '0;
    for (int i = 0; i < NCFG; i++) m_ready[i] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic push_beat(input logic [68:0] w);
    s_valid = 1'b1;
    s_word  = w;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    flush   = 1'b0;
    s_valid = 1'b0;
    s_word  = '0;
    for (int i = 0; i < NCFG; i++) m_ready[i] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (s_ready[0] !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b want 1", s_ready[0]); end
    checks++; if (m_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid[0]); end
    checks++; if (cnt[0] !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", cnt[0]); end
    checks++; if (af[0] !== 1'b0) begin errors++; $display("FAIL reset_almost_full got %b want 0", af[0]); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    logic [68:0] beats [4];
    logic        af_exp [4];
    af_exp = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) beats[i] = mk(4'(i + 1), 32'h1000 * (i + 1), 8'(16 * i + 3));
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_word  = beats[i];
      @(negedge clk);
      checks++; if (s_ready[0] !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d] got %b want 1", i, s_ready[0]); end
      @(posedge clk); #1;
      s_valid = 1'b0;
      @(negedge clk);
      checks++; if (cnt[0] !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d want %0d", i, cnt[0], i + 1); end
      checks++; if (af[0] !== af_exp[i]) begin errors++; $display("FAIL fill_af[%0d] got %b want %b", i, af[0], af_exp[i]); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (s_ready[0] !== 1'b0) begin errors++; $display("FAIL full_s_ready got %b want 0", s_ready[0]); end
    @(posedge clk); #1;
    m_ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (m_valid[0] !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got %b want 1", i, m_valid[0]); end
      checks++; if (m_word[0] !== beats[i]) begin errors++; $display("FAIL drain_data[%0d] got %h want %h", i, m_word[0], beats[i]); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (cnt[0] !== 3'd0) begin errors++; $display("FAIL drain_count got %0d want 0", cnt[0]); end
    checks++; if (m_valid[0] !== 1'b0) begin errors++; $display("FAIL drain_empty_valid got %b want 0", m_valid[0]); end
    @(posedge clk); #1;
    m_ready[0] = 1'b0;
  endtask

  task automatic test_stream();
    logic [68:0] q [$];
    logic [68:0] exp;
    int pushed = 0;
    int popped = 0;
    int cyc    = 0;
    bit took;
    apply_reset();
    while (popped < 1000 && cyc < 8000) begin
      if (!s_valid && pushed < 1000) begin
        s_valid = ($urandom_range(0, 9) < 8);
        s_word  = 69'({$urandom(), $urandom(), $urandom()});
      end
      m_ready[1] = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      checks++; if (cnt[1] > 3'd3) begin errors++; $display("FAIL stream_count got %0d want <=3", cnt[1]); end
      if (m_valid[1] && m_ready[1]) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL stream_underflow got pop want no pop");
        end else begin
          exp = q.pop_front();
          if (m_word[1] !== exp) begin errors++; $display("FAIL stream_data[%0d] got %h want %h", popped, m_word[1], exp); end
        end
        popped++;
      end
      took = s_valid && s_ready[1];
      if (took) begin
        q.push_back(s_word);
        pushed++;
      end
      @(posedge clk); #1;
      if (took) s_valid = 1'b0;
      cyc++;
    end
    checks++; if (popped != 1000) begin errors++; $display("FAIL stream_popped got %0d want 1000", popped); end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL stream_left got %0d want 0", q.size()); end
    s_valid    = 1'b0;
    m_ready[1] = 1'b0;
  endtask

  task automatic test_fall_through();
    logic [68:0] d1, d2;
    d1 = mk(4'h7, 32'hDEAD_0000, 8'h11);
    d2 = mk(4'h8, 32'hDEAD_0001, 8'h22);
    apply_reset();
    m_ready[2] = 1'b1;
    s_valid    = 1'b1;
    s_word     = d1;
    @(negedge clk);
    checks++; if (m_valid[2] !== 1'b1) begin errors++; $display("FAIL ft_bypass_valid got %b want 1", m_valid[2]); end
    checks++; if (m_word[2] !== d1) begin errors++; $display("FAIL ft_bypass_data got %h want %h", m_word[2], d1); end
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    checks++; if (cnt[2] !== 3'd0) begin errors++; $display("FAIL ft_bypass_count got %0d want 0", cnt[2]); end
    checks++; if (m_valid[2] !== 1'b0) begin errors++; $display("FAIL ft_idle_valid got %b want 0", m_valid[2]); end
    @(posedge clk); #1;
    m_ready[2] = 1'b0;
    s_valid    = 1'b1;
    s_word     = d2;
    @(negedge clk);
    checks++; if (m_valid[2] !== 1'b1) begin errors++; $display("FAIL ft_mirror_valid got %b want 1", m_valid[2]); end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_word  = mk(4'h3, 32'h0BAD_0BAD, 8'h33);
    @(negedge clk);
    checks++; if (cnt[2] !== 3'd1) begin errors++; $display("FAIL ft_store_count got %0d want 1", cnt[2]); end
    checks++; if (m_valid[2] !== 1'b1) begin errors++; $display("FAIL ft_store_valid got %b want 1", m_valid[2]); end
    checks++; if (m_word[2] !== d2) begin errors++; $display("FAIL ft_store_data got %h want %h", m_word[2], d2); end
    @(posedge clk); #1;
    m_ready[2] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (cnt[2] !== 3'd0) begin errors++; $display("FAIL ft_drain_count got %0d want 0", cnt[2]); end
    @(posedge clk); #1;
    m_ready[2] = 1'b0;
  endtask

  task automatic test_flush();
    logic [68:0] b5;
    b5 = mk(4'h5, 32'h5000, 8'h55);
    apply_reset();
    push_beat(mk(4'h1, 32'hA000, 8'h01));
    push_beat(mk(4'h2, 32'hB000, 8'h02));
    s_valid = 1'b1;
    s_word  = mk(4'h3, 32'hC000, 8'h03);
    flush   = 1'b1;
    @(negedge clk);
    checks++; if (s_ready[0] !== 1'b0) begin errors++; $display("FAIL flush_s_ready got %b want 0", s_ready[0]); end
    checks++; if (m_valid[0] !== 1'b0) begin errors++; $display("FAIL flush_m_valid got %b want 0", m_valid[0]); end
    @(posedge clk); #1;
    flush  = 1'b0;
    s_word = b5;
    @(negedge clk);
    checks++; if (cnt[0] !== 3'd0) begin errors++; $display("FAIL flush_count got %0d want 0", cnt[0]); end
    checks++; if (m_valid[0] !== 1'b0) begin errors++; $display("FAIL flush_after_valid got %b want 0", m_valid[0]); end
    checks++; if (s_ready[0] !== 1'b1) begin errors++; $display("FAIL flush_after_ready got %b want 1", s_ready[0]); end
    @(posedge clk); #1;
    s_valid    = 1'b0;
    m_ready[0] = 1'b1;
    @(negedge clk);
    checks++; if (m_valid[0] !== 1'b1) begin errors++; $display("FAIL flush_first_valid got %b want 1", m_valid[0]); end
    checks++; if (m_word[0] !== b5) begin errors++; $display("FAIL flush_first_data got %h want %h", m_word[0], b5); end
    checks++; if (cnt[0] !== 3'd1) begin errors++; $display("FAIL flush_first_count got %0d want 1", cnt[0]); end
    @(posedge clk); #1;
    m_ready[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 3; i++) push_beat(mk(4'(i + 9), 32'h7000 + 32'(i), 8'(i)));
    @(negedge clk);
    checks++; if (m_valid[0] !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid got %b want 1", m_valid[0]); end
    checks++; if (cnt[0] !== 3'd3) begin errors++; $display("FAIL midrst_pre_count got %0d want 3", cnt[0]); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (cnt[0] !== 3'd0) begin errors++; $display("FAIL midrst_count got %0d want 0", cnt[0]); end
    checks++; if (m_valid[0] !== 1'b0) begin errors++; $display("FAIL midrst_m_valid got %b want 0", m_valid[0]); end
    checks++; if (s_ready[0] !== 1'b1) begin errors++; $display("FAIL midrst_s_ready got %b want 1", s_ready[0]); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_stream();
    test_fall_through();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
